// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures incoming hsync/vsync timing, locks onto the expected
// mode after consecutive good frames and recovers pixel coordinates while locked.
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 31,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active_video,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        new_frame,
  output logic        timing_err
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [10:0] L_HTOTAL = 11'(H_TOTAL);
  localparam logic [10:0] L_HSYNC  = 11'(H_SYNC);
  localparam logic [10:0] L_HSTART = 11'(H_SYNC + H_BP);
  localparam logic [10:0] L_HEND   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  L_VTOTAL = 10'(V_TOTAL);
  localparam logic [9:0]  L_VSTART = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  L_VEND   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [7:0]  L_LOCK   = 8'(LOCK_FRAMES);

  logic        r_hsQ;
  logic        r_vsQ;
  logic [10:0] r_hcnt;
  logic [10:0] r_hsWidth;
  logic [10:0] r_lineLen;
  logic [9:0]  r_vcnt;
  logic [9:0]  r_frameLines;
  logic        r_badSeen;
  logic        r_newFrame;
  state_t      r_state;
  logic [7:0]  r_goodCnt;
  logic        r_locked;
  logic        r_timingErr;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_active;

  logic        w_hsFall;
  logic        w_hsRise;
  logic        w_vsFall;
  logic [10:0] w_hcntInc;
  logic [9:0]  w_vcntInc;
  logic        w_lineBad;
  logic        w_frameBad;
  logic        w_syncLoss;
  logic        w_inH;
  logic        w_inV;
  logic        w_act;

  // Edges are detected against the previous registered sample, so the counter
  // reset lands on the same clock that first sees the new level.
  assign w_hsFall   = r_hsQ & ~hsync_in;
  assign w_hsRise   = ~r_hsQ & hsync_in;
  assign w_vsFall   = r_vsQ & ~vsync_in;
  assign w_hcntInc  = (r_hcnt == 11'h7FF) ? r_hcnt : r_hcnt + 11'd1;
  assign w_vcntInc  = (r_vcnt == 10'h3FF) ? r_vcnt : r_vcnt + 10'd1;
  assign w_lineBad  = (w_hcntInc != L_HTOTAL) || (r_hsWidth != L_HSYNC);
  assign w_frameBad = (w_vcntInc != L_VTOTAL) || r_badSeen || (w_hsFall && w_lineBad);
  assign w_syncLoss = (r_hcnt == 11'h7FF);
  assign w_inH      = (r_hcnt >= L_HSTART) && (r_hcnt <= L_HEND);
  assign w_inV      = (r_vcnt >= L_VSTART) && (r_vcnt <= L_VEND);
  assign w_act      = r_locked && w_inH && w_inV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsQ        <= 1'b1;
      r_vsQ        <= 1'b1;
      r_hcnt       <= '0;
      r_hsWidth    <= '0;
      r_lineLen    <= '0;
      r_vcnt       <= '0;
      r_frameLines <= '0;
      r_badSeen    <= 1'b0;
      r_newFrame   <= 1'b0;
    end else begin
      r_hsQ      <= hsync_in;
      r_vsQ      <= vsync_in;
      r_newFrame <= w_vsFall;
      if (w_hsFall) begin
        r_hcnt    <= '0;
        r_lineLen <= w_hcntInc;
      end else begin
        r_hcnt <= w_hcntInc;
      end
      if (w_hsRise)
        r_hsWidth <= w_hcntInc;
      if (w_vsFall) begin
        r_vcnt       <= '0;
        r_frameLines <= w_vcntInc;
      end else if (w_hsFall) begin
        r_vcnt <= w_vcntInc;
      end
      // A bad line ending on the vsync edge belongs to the frame closing there.
      if (w_vsFall)
        r_badSeen <= 1'b0;
      else if (w_hsFall && w_lineBad)
        r_badSeen <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_goodCnt   <= '0;
      r_locked    <= 1'b0;
      r_timingErr <= 1'b0;
    end else begin
      r_timingErr <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_vsFall) begin
            r_state   <= VERIFY;
            r_goodCnt <= '0;
          end
        end
        VERIFY: begin
          if (w_vsFall) begin
            if (w_frameBad) begin
              r_goodCnt <= '0;
            end else if ((r_goodCnt + 8'd1) >= L_LOCK) begin
              r_goodCnt <= r_goodCnt + 8'd1;
              r_state   <= LOCKED;
              r_locked  <= 1'b1;
            end else begin
              r_goodCnt <= r_goodCnt + 8'd1;
            end
          end
        end
        LOCKED: begin
          if ((w_hsFall && w_lineBad) || (w_vsFall && w_frameBad) || w_syncLoss) begin
            r_state     <= SEARCH;
            r_locked    <= 1'b0;
            r_timingErr <= 1'b1;
            r_goodCnt   <= '0;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_active <= 1'b0;
    end else begin
      r_active <= w_act;
      r_x      <= w_act ? (r_hcnt[9:0] - L_HSTART[9:0]) : 10'd0;
      r_y      <= w_act ? (r_vcnt - L_VSTART) : 10'd0;
    end
  end

  assign x            = r_x;
  assign y            = r_y;
  assign active_video = r_active;
  assign line_len     = r_lineLen;
  assign frame_lines  = r_frameLines;
  assign locked       = r_locked;
  assign new_frame    = r_newFrame;
  assign timing_err   = r_timingErr;

endmodule
